// File: rtl/ram_copy_ctrl_pkg.sv
// Shared types and default sizing for the RAM block-copy initiator.
package ram_copy_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_HOLD  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam int DEF_AW        = 8;
    localparam int DEF_DW        = 8;
    localparam int DEF_MEM_DEPTH = 11;

endpackage

// File: rtl/ram_copy_ctrl.sv
// Copies len bytes from src_addr to dst_addr over an 8-bit asynchronous RAM port.
// Optional RAM_COPY_CHECKSUM_EN adds a modulo-2^DW sum of the bytes read.
module ram_copy_ctrl
    import ram_copy_ctrl_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] direccion,
    output logic [DW-1:0] Dato_E,
    output logic          EN,
    input  logic [DW-1:0] dato_s
`ifdef RAM_COPY_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    localparam logic [AW:0] W_DEPTH = (AW+1)'(MEM_DEPTH);

    state_t        r_state,  w_state_nx;
    logic [AW-1:0] r_src,    w_src_nx;
    logic [AW-1:0] r_dst,    w_dst_nx;
    logic [AW-1:0] r_len,    w_len_nx;
    logic [AW-1:0] r_idx,    w_idx_nx;
    logic          r_busy,   w_busy_nx;
    logic          r_done,   w_done_nx;
    logic          r_err,    w_err_nx;
    logic [AW-1:0] r_dir,    w_dir_nx;
    logic [DW-1:0] r_dato,   w_dato_nx;
    logic          r_en,     w_en_nx;
`ifdef RAM_COPY_CHECKSUM_EN
    logic [DW-1:0] r_sum,    w_sum_nx;
`endif

    logic [AW:0]   w_src_end;
    logic [AW:0]   w_dst_end;
    logic          w_oor;
    logic [AW-1:0] w_idx_inc;

    // Range check carried in AW+1 bits so src+len cannot wrap past the top.
    assign w_src_end = {1'b0, src_addr} + {1'b0, len};
    assign w_dst_end = {1'b0, dst_addr} + {1'b0, len};
    assign w_oor     = (w_src_end > W_DEPTH) || (w_dst_end > W_DEPTH);
    assign w_idx_inc = r_idx + 1'b1;

    always_comb begin
        w_state_nx = r_state;
        w_src_nx   = r_src;
        w_dst_nx   = r_dst;
        w_len_nx   = r_len;
        w_idx_nx   = r_idx;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_err_nx   = 1'b0;
        w_dir_nx   = r_dir;
        w_dato_nx  = r_dato;
        w_en_nx    = 1'b0;
`ifdef RAM_COPY_CHECKSUM_EN
        w_sum_nx   = r_sum;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        w_state_nx = S_FIN;
                        w_done_nx  = 1'b1;
`ifdef RAM_COPY_CHECKSUM_EN
                        w_sum_nx   = '0;
`endif
                    end else if (w_oor) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_src_nx   = src_addr;
                        w_dst_nx   = dst_addr;
                        w_len_nx   = len;
                        w_idx_nx   = '0;
                        w_busy_nx  = 1'b1;
                        w_dir_nx   = src_addr;
                        w_state_nx = S_READ;
`ifdef RAM_COPY_CHECKSUM_EN
                        w_sum_nx   = '0;
`endif
                    end
                end
            end
            S_READ: begin
                // Dato_E doubles as the byte register: it captures dato_s here.
                w_dato_nx  = dato_s;
                w_dir_nx   = r_dst + r_idx;
                w_en_nx    = 1'b1;
                w_state_nx = S_WRITE;
`ifdef RAM_COPY_CHECKSUM_EN
                w_sum_nx   = r_sum + dato_s;
`endif
            end
            S_WRITE: begin
                w_state_nx = S_HOLD;
            end
            S_HOLD: begin
                w_idx_nx = w_idx_inc;
                if (w_idx_inc == r_len) begin
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                    w_state_nx = S_FIN;
                end else begin
                    w_dir_nx   = r_src + w_idx_inc;
                    w_state_nx = S_READ;
                end
            end
            S_FIN: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_dir   <= '0;
            r_dato  <= '0;
            r_en    <= 1'b0;
`ifdef RAM_COPY_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
            r_dir   <= w_dir_nx;
            r_dato  <= w_dato_nx;
            r_en    <= w_en_nx;
`ifdef RAM_COPY_CHECKSUM_EN
            r_sum   <= w_sum_nx;
`endif
        end
    end

    // Latched request parameters are only meaningful while busy.
    always_ff @(posedge clk) begin
        r_src <= w_src_nx;
        r_dst <= w_dst_nx;
        r_len <= w_len_nx;
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign direccion = r_dir;
    assign Dato_E    = r_dato;
    assign EN        = r_en;
`ifdef RAM_COPY_CHECKSUM_EN
    assign checksum  = r_sum;
`endif

endmodule
